// File: rtl/remove_v_pkg.sv
// Shared types for the vertical border remover: per-flux state machine encoding
// and the context record kept for each flux.
package remove_v_pkg;

  localparam int TOP_ROWS_DEF = 3;
  localparam int BOT_ROWS_DEF = 4;
  localparam int CNT_W        = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DROP_TOP = 2'd1,
    ST_PASS     = 2'd2,
    ST_DROP_BOT = 2'd3
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
  } ctx_t;

  localparam ctx_t CTX_RESET = '{state: ST_IDLE, n: 7'd0, col: 7'd0, row: 7'd0};

endpackage

// File: rtl/remove_v_ctx.sv
// Context register bank: one entry per flux, read by tag, written with enable.
// All entry states are also exported so the arbiter can evaluate every flux at once.
module remove_v_ctx
  import remove_v_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_WIDTH-1:0]  rd_tag,
  output ctx_t                  rd_ctx,
  output state_t [FLUX-1:0]     state_all,
  input  logic                  wr_en,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  ctx_t                  wr_ctx
);

  ctx_t bank_r [FLUX];

  // Bank update: reset clears every flux, otherwise only the addressed entry changes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        bank_r[f] <= CTX_RESET;
      end
    end else if (wr_en) begin
      bank_r[wr_tag] <= wr_ctx;
    end
  end

  assign rd_ctx = bank_r[rd_tag];

  // Expose every flux state for eligibility evaluation
  always_comb begin
    state_all = '0;
    for (int f = 0; f < FLUX; f++) begin
      state_all[f] = bank_r[f].state;
    end
  end

endmodule

// File: rtl/remove_v_border.sv
// Drops TOP_ROWS rows above and BOT_ROWS rows below each N-wide block on several
// tagged fluxes; one flux (lowest eligible tag) advances per cycle, zero-latency handshake.
module remove_v_border
  import remove_v_pkg::*;
#(
  parameter int FLUX              = 2,
  parameter int DATA_WIDTH_IN_OUT = 18,
  parameter int DATA_WIDTH_EXT    = 7,
  parameter int TOP_ROWS          = TOP_ROWS_DEF,
  parameter int BOT_ROWS          = BOT_ROWS_DEF,
  parameter int TAG_WIDTH         = $clog2(FLUX),
  parameter int WIDTH             = DATA_WIDTH_IN_OUT + TAG_WIDTH,
  parameter int WIDTH_EXT         = DATA_WIDTH_EXT + TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     read_port_in_pel_dout,
  input  logic [FLUX-1:0]      read_port_in_pel_empty,
  output logic [FLUX-1:0]      read_port_in_pel_read,
  input  logic [WIDTH_EXT-1:0] read_port_ext_size_dout,
  input  logic [FLUX-1:0]      read_port_ext_size_empty,
  output logic [FLUX-1:0]      read_port_ext_size_read,
  output logic [WIDTH-1:0]     write_port_out_pel_din,
  input  logic [FLUX-1:0]      write_port_out_pel_full,
  output logic [FLUX-1:0]      write_port_out_pel_write
);

  state_t [FLUX-1:0]    state_all_s;
  logic   [FLUX-1:0]    elig_s;
  logic                 fire_s;
  logic [TAG_WIDTH-1:0] tag_s;
  logic [FLUX-1:0]      tag_oh_s;
  ctx_t                 cur_s;
  ctx_t                 nxt_s;
  logic [CNT_W-1:0]     n_in_s;
  logic [CNT_W-1:0]     row_last_s;
  state_t               adv_state_s;
  logic                 do_pel_s;
  logic                 do_ext_s;
  logic                 do_wr_s;

  remove_v_ctx #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_ctx (
    .clk       (clk),
    .rst       (rst),
    .rd_tag    (tag_s),
    .rd_ctx    (cur_s),
    .state_all (state_all_s),
    .wr_en     (fire_s && !rst),
    .wr_tag    (tag_s),
    .wr_ctx    (nxt_s)
  );

  assign n_in_s = CNT_W'(read_port_ext_size_dout[DATA_WIDTH_EXT-1:0]);

  // Per-flux eligibility from its own state and port status only
  always_comb begin
    elig_s = '0;
    for (int f = 0; f < FLUX; f++) begin
      case (state_all_s[f])
        ST_IDLE:     elig_s[f] = !read_port_ext_size_empty[f];
        ST_DROP_TOP: elig_s[f] = !read_port_in_pel_empty[f];
        ST_PASS:     elig_s[f] = !read_port_in_pel_empty[f] && !write_port_out_pel_full[f];
        ST_DROP_BOT: elig_s[f] = !read_port_in_pel_empty[f];
        default:     elig_s[f] = 1'b0;
      endcase
    end
  end

  // Fixed priority: scanning downward leaves the lowest eligible index in tag_s
  always_comb begin
    tag_s = '0;
    for (int f = FLUX - 1; f >= 0; f--) begin
      if (elig_s[f]) begin
        tag_s = TAG_WIDTH'(f);
      end else begin
        tag_s = tag_s;
      end
    end
  end

  assign fire_s   = |elig_s;
  assign tag_oh_s = {{(FLUX-1){1'b0}}, 1'b1} << tag_s;

  // Next context of the firing flux: row geometry selected by state, then common column/row walk
  always_comb begin
    nxt_s       = cur_s;
    do_pel_s    = 1'b0;
    do_ext_s    = 1'b0;
    do_wr_s     = 1'b0;
    row_last_s  = 7'd0;
    adv_state_s = cur_s.state;
    case (cur_s.state)
      ST_IDLE: begin
        do_ext_s    = 1'b1;
        nxt_s.n     = n_in_s;
        nxt_s.col   = 7'd0;
        nxt_s.row   = 7'd0;
        nxt_s.state = (n_in_s == 7'd0) ? ST_IDLE : ST_DROP_TOP;
      end
      ST_DROP_TOP: begin
        do_pel_s    = 1'b1;
        row_last_s  = CNT_W'(TOP_ROWS - 1);
        adv_state_s = ST_PASS;
      end
      ST_PASS: begin
        do_pel_s    = 1'b1;
        do_wr_s     = 1'b1;
        row_last_s  = cur_s.n - 7'd1;
        adv_state_s = ST_DROP_BOT;
      end
      ST_DROP_BOT: begin
        do_pel_s    = 1'b1;
        row_last_s  = CNT_W'(BOT_ROWS - 1);
        adv_state_s = ST_IDLE;
      end
      default: begin
        nxt_s = CTX_RESET;
      end
    endcase
    if (do_pel_s) begin
      if (cur_s.col == cur_s.n - 7'd1) begin
        nxt_s.col = 7'd0;
        if (cur_s.row == row_last_s) begin
          nxt_s.row   = 7'd0;
          nxt_s.state = adv_state_s;
        end else begin
          nxt_s.row = cur_s.row + 7'd1;
        end
      end else begin
        nxt_s.col = cur_s.col + 7'd1;
      end
    end else begin
      nxt_s = nxt_s;
    end
  end

  // Handshake strobes are suppressed entirely while reset is held
  always_comb begin
    read_port_in_pel_read    = '0;
    read_port_ext_size_read  = '0;
    write_port_out_pel_write = '0;
    if (fire_s && !rst) begin
      read_port_in_pel_read    = do_pel_s ? tag_oh_s : '0;
      read_port_ext_size_read  = do_ext_s ? tag_oh_s : '0;
      write_port_out_pel_write = do_wr_s  ? tag_oh_s : '0;
    end else begin
      read_port_in_pel_read = '0;
    end
  end

  assign write_port_out_pel_din = {tag_s, read_port_in_pel_dout[DATA_WIDTH_IN_OUT-1:0]};

endmodule
